// File: rtl/micro_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// micro_sequencer : microprogram sequencer with loop counter and LIFO stack
// Revision 1.0
// ============================================================================
module micro_sequencer #(
  parameter int AW    = 12,
  parameter int DEPTH = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    op,
  input  logic          cc,
  input  logic [AW-1:0] d,
  input  logic [AW-1:0] orin,
  input  logic          cin,
  output logic [AW-1:0] y,
  output logic          full,
  output logic          empty,
  output logic          cnt_zero,
  output logic          err
);

  localparam int SPW = $clog2(DEPTH) + 1;
  localparam int IW  = SPW - 1;

  localparam logic [3:0] c_OP_JZ   = 4'd0;
  localparam logic [3:0] c_OP_CJS  = 4'd1;
  localparam logic [3:0] c_OP_JMAP = 4'd2;
  localparam logic [3:0] c_OP_CJP  = 4'd3;
  localparam logic [3:0] c_OP_PUSH = 4'd4;
  localparam logic [3:0] c_OP_RFCT = 4'd5;
  localparam logic [3:0] c_OP_CRTN = 4'd6;
  localparam logic [3:0] c_OP_LDCT = 4'd7;

  localparam logic [SPW-1:0] c_SP_FULL = SPW'(DEPTH);
  localparam logic [SPW-1:0] c_SP_ONE  = SPW'(1);
  localparam logic [IW-1:0]  c_IDX_ONE = IW'(1);
  localparam logic [AW-1:0]  c_CNT_ONE = AW'(1);

  logic [AW-1:0]  r_upc;
  logic [AW-1:0]  r_cnt;
  logic [SPW-1:0] r_sp;
  logic           r_err;
  logic [AW-1:0]  r_stack [DEPTH];

  logic [AW-1:0]  w_base;
  logic [AW-1:0]  w_top;
  logic [AW-1:0]  w_y;
  logic [IW-1:0]  w_rd_idx;
  logic           w_full;
  logic           w_empty;
  logic           w_push_req;
  logic           w_pop_req;
  logic           w_push_ok;
  logic           w_pop_ok;
  logic           w_fault;
  logic           w_load;
  logic           w_dec;
  logic           w_clr;

  assign w_full  = (r_sp == c_SP_FULL);
  assign w_empty = (r_sp == '0);

  // Low index bits minus one also lands on DEPTH-1 when sp==DEPTH.
  assign w_rd_idx = r_sp[IW-1:0] - c_IDX_ONE;
  assign w_top    = w_empty ? '0 : r_stack[w_rd_idx];

  always_comb begin
    w_base     = r_upc;
    w_push_req = 1'b0;
    w_pop_req  = 1'b0;
    w_load     = 1'b0;
    w_dec      = 1'b0;
    w_clr      = 1'b0;
    case (op)
      c_OP_JZ: begin
        w_base = '0;
        w_clr  = 1'b1;
      end
      c_OP_CJS: begin
        if (cc) begin
          w_base     = d;
          w_push_req = 1'b1;
        end
      end
      c_OP_JMAP: w_base = d;
      c_OP_CJP: begin
        if (cc) w_base = d;
      end
      c_OP_PUSH: begin
        w_push_req = 1'b1;
        w_load     = cc;
      end
      c_OP_RFCT: begin
        if (r_cnt != '0) begin
          w_base = w_top;
          w_dec  = 1'b1;
        end else begin
          w_pop_req = 1'b1;
        end
      end
      c_OP_CRTN: begin
        if (cc) begin
          w_base    = w_top;
          w_pop_req = 1'b1;
        end
      end
      c_OP_LDCT: w_load = 1'b1;
      default: ;
    endcase
  end

  assign w_push_ok = w_push_req & ~w_full;
  assign w_pop_ok  = w_pop_req & ~w_empty;
  assign w_fault   = (w_push_req & w_full) | (w_pop_req & w_empty);

  // y is forced to zero for the whole time reset is held.
  assign w_y = reset ? '0 : (w_base | orin);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_upc <= '0;
      r_cnt <= '0;
      r_sp  <= '0;
      r_err <= 1'b0;
    end else begin
      r_upc <= w_y + AW'(cin);

      if (w_load) begin
        r_cnt <= d;
      end else if (w_dec) begin
        r_cnt <= r_cnt - c_CNT_ONE;
      end

      if (w_clr) begin
        r_sp <= '0;
      end else if (w_push_ok) begin
        r_sp <= r_sp + c_SP_ONE;
      end else if (w_pop_ok) begin
        r_sp <= r_sp - c_SP_ONE;
      end

      if (w_clr) begin
        r_err <= 1'b0;
      end else if (w_fault) begin
        r_err <= 1'b1;
      end
    end
  end

  // Stack storage carries no reset; entries above sp are never read.
  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_stack[r_sp[IW-1:0]] <= r_upc;
    end
  end

  assign y        = w_y;
  assign full     = w_full;
  assign empty    = w_empty;
  assign cnt_zero = (r_cnt == '0);
  assign err      = r_err;

endmodule
`default_nettype wire
